// File: rtl/fsqrt_nr.sv
// fsqrt_nr: Newton-Raphson refinement of a 1/sqrt(x) seed into a float32 sqrt(x).
// One shared 32x32 multiplier; the FSM picks its operands each cycle.
// Fixed point values are Q2.30 unsigned; all of them stay below 4.
module fsqrt_nr #(
    parameter int ITER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y0,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [2:0] {IDLE, SQ, MA, UPD, FIN, PACK, DONE} state_t;
    typedef enum logic [1:0] {SP_NORM, SP_ZERO, SP_NAN, SP_INF} spc_t;

    localparam logic [31:0] THREE  = 32'hC000_0000;  // 3.0 in Q2.30
    localparam logic [31:0] R_DFLT = 32'h3000_0000;  // 0.75 fallback seed
    localparam logic [2:0]  ITER_C = 3'(ITER);

    state_t state, state_nxt;
    logic [31:0] a, r, t, q;
    logic signed [9:0] k;
    spc_t spc;
    logic sgn;
    logic [2:0] cnt;
    logic accept;

    // capture-side decode
    logic [7:0]  e;
    logic [22:0] m;
    logic [9:0]  ediff, sexp;
    logic signed [9:0] kc;
    logic [31:0] a_c, r_c;
    spc_t spc_c;

    // multiplier
    logic [31:0] mul_a, mul_b;
    logic [63:0] prod;

    // pack
    logic [25:0] qr;
    logic [9:0]  eo, eo_adj;
    logic [22:0] mant;
    logic [31:0] y_pk;

    assign e = x[30:23];
    assign m = x[22:0];
    assign accept = in_valid && in_ready;

    // Operand alignment, exponent halving, seed scaling and special-case decode
    always_comb begin
        ediff = {2'b00, e} - 10'd127;
        kc    = $signed(ediff) >>> 1;
        sexp  = {2'b00, y0[30:23]} + $unsigned(kc);
        // odd e: a = 1.m; even e: a = 2 * 1.m, so a is in [1,4)
        a_c   = e[0] ? {2'b01, m, 7'b0} : {1'b1, m, 8'b0};
        case (sexp)
            10'd127: r_c = {2'b01, y0[22:0], 7'b0};
            10'd126: r_c = {3'b001, y0[22:0], 6'b0};
            default: r_c = R_DFLT;
        endcase
        if (e == 8'd0)                      spc_c = SP_ZERO;
        else if (x[31])                     spc_c = SP_NAN;
        else if (e == 8'hFF && m != 23'd0)  spc_c = SP_NAN;
        else if (e == 8'hFF)                spc_c = SP_INF;
        else                                spc_c = SP_NORM;
    end

    // Shared multiplier operand selection per FSM step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SQ:      begin mul_a = r; mul_b = r;         end
            MA:      begin mul_a = a; mul_b = t;         end
            UPD:     begin mul_a = r; mul_b = THREE - t; end
            FIN:     begin mul_a = a; mul_b = r;         end
            default: ;
        endcase
        prod = 64'(mul_a) * 64'(mul_b);
    end

    // Round q to 23 fraction bits and renormalise into the result word
    always_comb begin
        qr     = {1'b0, q[31:7]} + 26'(q[6]);
        eo     = 10'd127 + $unsigned(k);
        eo_adj = eo;
        mant   = qr[22:0];
        if (qr >= 26'h100_0000) begin
            mant   = '0;
            eo_adj = eo + 10'd1;
        end else if (qr < 26'h080_0000) begin
            mant   = {qr[21:0], 1'b0};
            eo_adj = eo - 10'd1;
        end
        case (spc)
            SP_ZERO: y_pk = {sgn, 31'b0};
            SP_NAN:  y_pk = 32'h7fc0_0000;
            SP_INF:  y_pk = 32'h7f80_0000;
            default: y_pk = {1'b0, eo_adj[7:0], mant};
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one multiply per state, fixed iteration count
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = SQ;
            SQ:   state_nxt = MA;
            MA:   state_nxt = UPD;
            UPD:  state_nxt = (cnt + 3'd1 == ITER_C) ? FIN : SQ;
            FIN:  state_nxt = PACK;
            PACK: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath registers: capture, refine, pack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a   <= '0;
            r   <= '0;
            t   <= '0;
            q   <= '0;
            k   <= '0;
            spc <= SP_NORM;
            sgn <= 1'b0;
            cnt <= '0;
            y   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a   <= a_c;
                    r   <= r_c;
                    k   <= kc;
                    spc <= spc_c;
                    sgn <= x[31];
                    cnt <= '0;
                end
                SQ:   t <= prod[61:30];
                MA:   t <= prod[61:30];
                UPD: begin
                    r   <= {1'b0, prod[61:31]};
                    cnt <= cnt + 3'd1;
                end
                FIN:  q <= prod[61:30];
                PACK: y <= y_pk;
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{prod[63:62], prod[29:0], q[5:0], y0[31], eo_adj[9:8]};
endmodule

// File: doc/fsqrt_nr.md
Name: fsqrt_nr

Overview:
- Multi-cycle Newton-Raphson refinement stage for single-precision square root.
- Sits directly downstream of sqrt_init: consumes the operand x and sqrt_init's 1/sqrt(x) seed y0, and refines the reciprocal root.
- Multiplies by the normalised operand and returns sqrt(x) as float32.
- Uses one shared 32x32 fixed-point multiplier, sequenced by an FSM, behind valid/ready handshakes.

Parameters:
ITER, 2, number of Newton-Raphson iterations (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
x  input  32  float32 operand
y0  input  32  seed from sqrt_init for the same x
in_valid  input  1  x/y0 valid
in_ready  output  1  block can accept
y  output  32  float32 sqrt(x)
out_valid  output  1  y valid
out_ready  input  1  consumer accepts y

Behaviour:
- One clock; reset is asynchronous and active-high (rst), clock is clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=32'h0, all datapath registers 0.
- Reset mid-operation aborts the operation immediately; no output is produced.

Handshake:
- in_ready=1 only in IDLE.
- Accept edge: in_valid && in_ready.
- out_valid is held, with y stable, until out_valid && out_ready; that edge returns to IDLE.
- No new accept can occur on the same edge as the output handshake.

Capture (accept edge):
- Split x into s, e=x[30:23], m=x[22:0].
- k = floor((e-127)/2), signed; in hardware, k = (e-127)>>>1 on 10 bits.
- Operand a, Q2.30, in [1,4): {1,m} aligned so a = 1.m when e is odd, a = 2*1.m when e is even.
- Seed r, Q2.30: r = 1.my0 * 2^(ye0+k-127).
  - ye0+k is always 126 or 127 for sqrt_init seeds.
  - If ye0+k is outside {126,127}, r := 0.75.
- Special-case code: latched from x; selects the output in PACK.

FSM states: IDLE, SQ, MA, UPD, FIN, PACK, DONE.
- IDLE -> SQ on accept.
- SQ: t <= trunc(r*r).
- MA: t <= trunc(a*t).
- UPD: r <= trunc(r*(3-t)) >> 1; iteration counter +1.
- UPD -> SQ while count < ITER; UPD -> FIN when count == ITER.
- FIN: q <= trunc(a*r), which approximates sqrt(a) in [1,2).
- PACK -> DONE; out_valid rises on this edge.

Arithmetic and width rules:
- All multiplies are unsigned 32x32 -> 64 bits.
- trunc() keeps product bits [61:30] (Q2.30); no saturation is needed because every value is < 4.
- 3-t is Q2.30 unsigned; t < 3 is guaranteed.

Latency:
- out_valid asserts 3*ITER+3 rising edges after the accept edge (9 for ITER=2), counting the accept edge.
- Latency is fixed for all inputs, including special cases.

PACK rounding:
- Round q to 23 fraction bits, round-half-up at q bit 6.
- eo = 127+k.
- If the rounded value is >= 2: mantissa 0, eo+1.
- If the rounded value is < 1: shift left 1, eo-1.
- y = {0, eo[7:0], mantissa}.

Special cases, resolved in PACK and overriding the datapath:
- e==0 (zero or denormal, flushed) -> {s, 31'b0}.
- s==1 and e!=0 -> 32'h7fc00000.
- e==255, m!=0 -> 32'h7fc00000.
- e==255, m==0, s==0 -> 32'h7f800000.

Accuracy:
- Normal positive x, ITER>=2: |y - correctly rounded sqrt(x)| <= 1 ulp.
- Exact results are required for x = 4^n.

Test Plan:
- Reset, then x=32'h3f800000 (1.0), y0=32'h3f800000, in_valid=1 for one cycle.
  - in_ready drops next cycle; out_valid rises exactly 9 edges after the accept edge.
  - y=32'h3f800000.
- x=32'h40800000 (4.0), y0=32'h3f000000 -> y=32'h40000000 exact.
- x=32'h40000000 (2.0), y0=32'h3f340000 -> y within 1 ulp of 32'h3fb504f3.
- Special cases:
  - x=32'h80000000 -> 32'h80000000.
  - x=32'hc0800000 -> 32'h7fc00000.
  - x=32'h7f800000 -> 32'h7f800000.
  - x=32'h00012345 -> 32'h00000000.
  - Each appears with the same 9-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - y stays stable and in_ready stays 0.
  - Raise out_ready: one transfer, then IDLE with in_ready=1 the next cycle.
- Assert rst during UPD of iteration 1.
  - out_valid=0, in_ready=1 immediately (asynchronous).
  - No output is produced; the next operation completes correctly.
- Random sweep of 10^5 positive normal x, with y0 from the sqrt_init model, for ITER=2: every result within 1 ulp of IEEE sqrt.
